mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath, executing MULT, MULTU, DIV and DIVU.
- Results go to architectural HI/LO registers.
- The hi and lo outputs drive two data inputs of the 32-bit, 4-input writeback/result select mux: ALU result, memory data, HI, LO. This serves MFHI/MFLO.
- Multi-cycle operation is reported to the hazard logic through busy and done, so the pipeline stalls MFHI/MFLO until the result is ready.

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 tb/tb_mult_div_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the issue logic and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wr_data,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wr_data,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One iteration per cycle: shift-add multiply, restoring divide on magnitudes,
// with sign correction applied in a final FIX cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned        PW   = 2 * WIDTH;
  localparam logic [CNT_W-1:0]   LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] count;
  logic             is_div;
  logic             sign_q;
  logic             sign_r;
  logic             div_zero;
  logic [WIDTH-1:0] opnd;      // multiplicand (mult) or divisor (div) magnitude
  logic [PW-1:0]    acc;       // product accumulator; low half holds quotient for div
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             signed_op;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_nx;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes for the request currently presented on the bus.
  always_comb begin
    signed_op = ~bus.op[0];
    rs_mag    = (signed_op && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    rt_mag    = (signed_op && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
  end

  // Single-iteration datapath and final sign correction.
  always_comb begin
    mul_sum   = {1'b0, acc[PW-1:WIDTH]} + {1'b0, opnd};
    mul_nx    = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[PW-1:1]};
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = ~div_diff[WIDTH];
    prod_fix  = sign_q ? -acc : acc;
    quo_fix   = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sign_r ? -rem : rem;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (count == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration, result writeback and MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      is_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_nx != IDLE);
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            count    <= '0;
            is_div   <= bus.op[1];
            sign_q   <= signed_op & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            sign_r   <= signed_op & bus.rs_val[WIDTH-1];
            div_zero <= bus.op[1] & (bus.rt_val == '0);
            opnd     <= bus.op[1] ? rt_mag : rs_mag;
            acc      <= {WIDTH'(0), (bus.op[1] ? rs_mag : rt_mag)};
            rem      <= '0;
          end else begin
            if (bus.mthi) hi_q <= bus.wr_data;
            if (bus.mtlo) lo_q <= bus.wr_data;
          end
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            rem             <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_nx;
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            // Divisor zero: quotient is all ones; remainder is |rs|, and
            // re-applying rs's sign recovers rs_val exactly.
            lo_q <= div_zero ? '1 : quo_fix;
            hi_q <= rem_fix;
          end else begin
            hi_q <= prod_fix[PW-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input bit disturb, input string tag);
    int n;
    int busy_cnt;
    bit seen;
    bus.start  = 1'b1;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    if (disturb) begin
      bus.mthi    = 1'b1;
      bus.mtlo    = 1'b1;
      bus.wr_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.op     = 2'b01;
    bus.rs_val = 32'h5A5A_5A5A;
    bus.rt_val = 32'hA5A5_A5A5;
    busy_cnt = bus.busy ? 1 : 0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1'b1;
      if (n == 10 && disturb) begin
        bus.start   = 1'b1;
        bus.mtlo    = 1'b1;
        bus.op      = 2'b00;
        bus.wr_data = 32'h1111_1111;
      end
      if (n == 11) begin
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
      end
      if (n == 16) begin
        check({tag, "_hold_hi"}, bus.hi, hold_hi);
        check({tag, "_hold_lo"}, bus.lo, hold_lo);
      end
    end
    check({tag, "_latency"}, 32'(n), 32'd33);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_val  = '0;
    bus.rt_val  = '0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.wr_data = '0;

    repeat (2) @(negedge clk);
    check("rst_hi",   bus.hi, 32'h0);
    check("rst_lo",   bus.lo, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    bus.mthi = 1'b1; bus.wr_data = 32'h0000_1234;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi_hi", bus.hi, 32'h0000_1234);
    check("mthi_lo", bus.lo, 32'h0);

    bus.mtlo = 1'b1; bus.wr_data = 32'h0000_5678;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mtlo_hi", bus.hi, 32'h0000_1234);
    check("mtlo_lo", bus.lo, 32'h0000_5678);

    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wr_data = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mtboth_hi", bus.hi, 32'hA5A5_A5A5);
    check("mtboth_lo", bus.lo, 32'hA5A5_A5A5);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    @(negedge clk);
    check("done_pulse_width", 32'(bus.done), 32'h0);
    check("idle_busy",        32'(bus.busy), 32'h0);

    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg");
    do_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
          32'h0000_0000, 32'hFFFF_FFFE, 1'b0, "mult_b2b");
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, "div_neg_disturb");
    do_op(2'b11, 32'd100, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
          32'd2, 32'd14, 1'b0, "divu_100_7");
    do_op(2'b11, 32'h0000_0064, 32'h0, 32'd2, 32'd14,
          32'h0000_0064, 32'hFFFF_FFFF, 1'b0, "divu_by_zero");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0064, 32'hFFFF_FFFF,
          32'h0000_0000, 32'h8000_0000, 1'b0, "div_overflow");
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0, 32'h0000_0000, 32'h8000_0000,
          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, "div_neg_by_zero");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
          32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minint_sq");

    // Reset in the middle of a MULT clears everything without a clock edge.
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_hi",   bus.hi, 32'h0);
    check("midrst_lo",   bus.lo, 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(2'b11, 32'd9, 32'd3, 32'h0, 32'h0, 32'h0, 32'd3, 1'b0, "divu_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
